// File: rtl/ru_wb_arbiter_if.sv
// Register-unit write-side bus: pipeline writeback and multicycle result inputs,
// the single register-unit write port, and the hazard-side status outputs.
interface ru_wb_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        mc_ready;
    logic        RUwrite;
    logic [4:0]  rd;
    logic [31:0] RUdw;
    logic [31:0] busy_mask;
    logic        starve_req;

    // Arbiter side.
    modport slave (
        input  pipe_we, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
        output mc_ready, RUwrite, rd, RUdw, busy_mask, starve_req
    );

    // Producer / register-unit side.
    modport master (
        output pipe_we, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
        input  mc_ready, RUwrite, rd, RUdw, busy_mask, starve_req
    );
endinterface

// File: rtl/ru_wb_arbiter.sv
// Write-side arbiter for the register unit. In-order pipeline results always win;
// out-of-order multicycle results wait in a small FIFO and drain into idle slots.
// The write port is registered, giving exactly one cycle from arbitration to RUwrite.
module ru_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic           clk,
    input  logic           rst,
    ru_wb_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [GW-1:0] AGE_SAT  = GW'(STARVE_MAX);

    // FIFO storage and bookkeeping
    logic [4:0]    ent_rd_q   [DEPTH];
    logic [31:0]   ent_data_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [GW-1:0] age_q,    age_d;

    // Registered write port
    logic          ru_write_q, ru_write_d;
    logic [4:0]    rd_q,       rd_d;
    logic [31:0]   ru_dw_q,    ru_dw_d;

    logic          pipe_eff, fifo_empty, fifo_full, push, pop;
    logic [31:0]   busy;
    logic [AW-1:0] slot_ofs;

    // Writes to x0 are architecturally void; the x0 mc result is still handshaken away.
    assign pipe_eff   = bus.pipe_we && (bus.pipe_rd != 5'd0);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign push       = bus.mc_valid && !fifo_full && (bus.mc_rd != 5'd0);
    assign pop        = !pipe_eff && !fifo_empty;

    // Arbitration, FIFO pointer/count and head-age next-state.
    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        ru_write_d = 1'b0;
        rd_d       = rd_q;
        ru_dw_d    = ru_dw_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        age_d      = age_q;

        if (pipe_eff) begin
            ru_write_d = 1'b1;
            rd_d       = bus.pipe_rd;
            ru_dw_d    = bus.pipe_data;
        end else if (pop) begin
            ru_write_d = 1'b1;
            rd_d       = ent_rd_q[rd_ptr_q];
            ru_dw_d    = ent_data_q[rd_ptr_q];
        end

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (pop || fifo_empty)  age_d = '0;
        else if (age_q != AGE_SAT) age_d = age_q + GW'(1);
    end

    // Control state and the registered write port, cleared by async reset.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            age_q      <= '0;
            ru_write_q <= 1'b0;
            rd_q       <= '0;
            ru_dw_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            age_q      <= age_d;
            ru_write_q <= ru_write_d;
            rd_q       <= rd_d;
            ru_dw_q    <= ru_dw_d;
        end
    end

    // FIFO entry storage, written on push.
    // NOTE: the entry array has no reset; count/pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_rd_q[wr_ptr_q]   <= bus.mc_rd;
            ent_data_q[wr_ptr_q] <= bus.mc_data;
        end
    end

    // Busy mask: one-hot destination of every occupied slot between head and tail.
    always_comb begin
        busy     = '0;
        slot_ofs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_ofs = AW'(i) - rd_ptr_q;
            if (CW'(slot_ofs) < count_q) busy[ent_rd_q[i]] = 1'b1;
        end
    end

    assign bus.mc_ready   = !fifo_full;
    assign bus.RUwrite    = ru_write_q;
    assign bus.rd         = rd_q;
    assign bus.RUdw       = ru_dw_q;
    assign bus.busy_mask  = busy;
    assign bus.starve_req = (age_q >= AGE_SAT);
endmodule

// File: tb/tb_ru_wb_arbiter.sv
// Self-checking bench for ru_wb_arbiter: directed vector table, hand-written
// fill/starve and mid-stream reset sequences, then random traffic against a
// queue-based reference model.
module tb_ru_wb_arbiter;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ru_wb_arbiter_if bus ();

    ru_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        bus.pipe_we   = pwe;
        bus.pipe_rd   = prd;
        bus.pipe_data = pd;
        bus.mc_valid  = mv;
        bus.mc_rd     = mrd;
        bus.mc_data   = md;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic w, input logic [4:0] r,
                              input logic [31:0] dw, input logic [31:0] busy,
                              input logic ready, input logic starve);
        check({tag, " RUwrite"},    128'(bus.RUwrite),    128'(w));
        check({tag, " rd"},         128'(bus.rd),         128'(r));
        check({tag, " RUdw"},       128'(bus.RUdw),       128'(dw));
        check({tag, " busy_mask"},  128'(bus.busy_mask),  128'(busy));
        check({tag, " mc_ready"},   128'(bus.mc_ready),   128'(ready));
        check({tag, " starve_req"}, 128'(bus.starve_req), 128'(starve));
    endtask

    // ---------------- reference model (queue of pending mc results) ----------------
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    int          m_age;
    logic        m_w;
    logic [4:0]  m_rd;
    logic [31:0] m_dw;

    function automatic void model_reset();
        m_q.delete();
        m_age = 0;
        m_w   = 1'b0;
        m_rd  = '0;
        m_dw  = '0;
    endfunction

    function automatic void model_step(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        bit accept    = mv && (m_q.size() < DEPTH);
        bit was_empty = (m_q.size() == 0);
        bit popped    = 1'b0;
        if (pwe && prd != 5'd0) begin
            m_w = 1'b1; m_rd = prd; m_dw = pd;
        end else if (!was_empty) begin
            ent_t h = m_q.pop_front();
            m_w = 1'b1; m_rd = h.rd; m_dw = h.data;
            popped = 1'b1;
        end else begin
            m_w = 1'b0;
        end
        if (popped || was_empty) m_age = 0;
        else if (m_age < STARVE_MAX) m_age++;
        if (accept && mrd != 5'd0) m_q.push_back('{rd: mrd, data: md});
    endfunction

    function automatic logic [71:0] model_outputs();
        logic [31:0] busy = '0;
        foreach (m_q[i]) busy[m_q[i].rd] = 1'b1;
        return {m_w, m_rd, m_dw, busy, logic'(m_q.size() < DEPTH), logic'(m_age >= STARVE_MAX)};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic        pwe;
        logic [4:0]  prd;
        logic [31:0] pd;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        exp_w;
        logic [4:0]  exp_rd;
        logic [31:0] exp_dw;
        logic [31:0] exp_busy;
        logic        exp_ready;
        logic        exp_starve;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // single pipeline write, then idle
        vecs[0]  = '{1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,  1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0};
        // mc rd=7 waits behind three pipeline writes to rd=3
        vecs[2]  = '{1'b1, 5'd3, 32'h30, 1'b1, 5'd7, 32'h11, 1'b1, 5'd3, 32'h30, 32'h80, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 5'd3, 32'h31, 1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h31, 32'h80, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 5'd3, 32'h32, 1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h32, 32'h80, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'h11, 32'h0,  1'b1, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd7, 32'h11, 32'h0,  1'b1, 1'b0};
        // two mc writes to rd=9 commit in arrival order
        vecs[7]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 32'h1,  1'b0, 5'd7, 32'h11, 32'h200, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 32'h2,  1'b1, 5'd9, 32'h1,  32'h200, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b1, 5'd9, 32'h2,  32'h0,   1'b1, 1'b0};
        vecs[10] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd9, 32'h2,  32'h0,   1'b1, 1'b0};
        // x0 on both sources: nothing is written or buffered
        vecs[11] = '{1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hFF, 1'b0, 5'd9, 32'h2,  32'h0,   1'b1, 1'b0};
        vecs[12] = '{1'b1, 5'd0, 32'hAB, 1'b1, 5'd0, 32'hFF, 1'b0, 5'd9, 32'h2,  32'h0,   1'b1, 1'b0};
        vecs[13] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  1'b0, 5'd9, 32'h2,  32'h0,   1'b1, 1'b0};
    end

    initial begin
        logic        pwe, mv;
        logic [4:0]  prd, mrd;
        logic [31:0] pd, md;

        // ---- power-on reset ----
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        tick();
        expect_out("reset", 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        rst = 1'b0;

        // ---- directed table ----
        foreach (vecs[i]) begin
            drive(vecs[i].pwe, vecs[i].prd, vecs[i].pd, vecs[i].mv, vecs[i].mrd, vecs[i].md);
            tick();
            expect_out($sformatf("vec%0d", i), vecs[i].exp_w, vecs[i].exp_rd, vecs[i].exp_dw,
                       vecs[i].exp_busy, vecs[i].exp_ready, vecs[i].exp_starve);
        end

        // ---- fill to DEPTH under pipeline pressure, starve, then drain ----
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd1, 32'h100 + 32'(k), 1'b1, 5'(10 + k), 32'hA0 + 32'(k));
            tick();
            check($sformatf("fill%0d mc_ready", k), 128'(bus.mc_ready), 128'(k < 3));
            check($sformatf("fill%0d rd", k), 128'(bus.rd), 128'd1);
        end
        check("fill busy_mask", 128'(bus.busy_mask), 128'h3C00);
        for (int k = 4; k <= 8; k++) begin
            drive(1'b1, 5'd1, 32'h100 + 32'(k), 1'b1, 5'd14, 32'hE0);
            tick();
            check($sformatf("hold%0d mc_ready", k), 128'(bus.mc_ready), 128'd0);
            check($sformatf("hold%0d busy_mask", k), 128'(bus.busy_mask), 128'h3C00);
            check($sformatf("hold%0d starve_req", k), 128'(bus.starve_req), 128'(k == 8));
        end
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'hE0);
        tick();
        expect_out("pop1", 1'b1, 5'd10, 32'hA0, 32'h3800, 1'b1, 1'b0);
        tick();
        expect_out("pop2", 1'b1, 5'd11, 32'hA1, 32'h7000, 1'b1, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        expect_out("pop3", 1'b1, 5'd12, 32'hA2, 32'h6000, 1'b1, 1'b0);
        tick();
        expect_out("pop4", 1'b1, 5'd13, 32'hA3, 32'h4000, 1'b1, 1'b0);
        tick();
        expect_out("pop5", 1'b1, 5'd14, 32'hE0, 32'h0, 1'b1, 1'b0);
        tick();
        check("drained RUwrite", 128'(bus.RUwrite), 128'd0);

        // ---- asynchronous reset with three entries in flight ----
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd2, 32'h22, 1'b1, 5'(20 + k), 32'(k));
            tick();
        end
        check("preload busy_mask", 128'(bus.busy_mask), 128'h0070_0000);
        drive(1'b1, 5'd2, 32'h23, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_out("async rst", 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        expect_out("post rst", 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);

        // ---- random traffic against the reference model ----
        model_reset();
        for (int c = 0; c < 400; c++) begin
            pwe = ($urandom_range(0, 99) < ((c < 200) ? 40 : 92));
            prd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            pd  = $urandom;
            mv  = ($urandom_range(0, 99) < 60);
            mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            md  = $urandom;
            drive(pwe, prd, pd, mv, mrd, md);
            model_step(pwe, prd, pd, mv, mrd, md);
            tick();
            check($sformatf("rand cycle %0d", c),
                  128'({bus.RUwrite, bus.rd, bus.RUdw, bus.busy_mask, bus.mc_ready, bus.starve_req}),
                  128'(model_outputs()));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
